reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 29 ++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// Signal bundle for reg_write_arbiter: two requester ports plus the register-file write port.
// master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  gnt0, gnt1, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output gnt0, gnt1, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter merging two register-file write requesters onto one write port.
// Define REG_WRITE_ARBITER_CLEAR_EN to build the post-reset sweep that zeroes all NUM_REGS registers.
module reg_write_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_write_arbiter_if.slave bus
);

    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              wr_en_q, wr_en_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              elig0, elig1;
    logic              arb_gnt0, arb_gnt1;
    logic              arb_ptr;
    logic [ADDR_W-1:0] arb_addr;
    logic [DATA_W-1:0] arb_data;

    // A requester granted last cycle is skipped so its still-held request is not written twice.
    always_comb begin
        elig0    = bus.req0 & ~gnt0_q;
        elig1    = bus.req1 & ~gnt1_q;
        arb_gnt0 = elig0 & (~elig1 | ~ptr_q);
        arb_gnt1 = elig1 & ~arb_gnt0;
        arb_ptr  = ptr_q;
        arb_addr = wr_addr_q;
        arb_data = wr_data_q;
        if (arb_gnt0) begin
            arb_ptr  = 1'b1;
            arb_addr = bus.addr0;
            arb_data = bus.data0;
        end else if (arb_gnt1) begin
            arb_ptr  = 1'b0;
            arb_addr = bus.addr1;
            arb_data = bus.data1;
        end
    end

`ifdef REG_WRITE_ARBITER_CLEAR_EN
    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_e;

    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // BUSY stays high through the write of the last register and drops as arbitration starts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        gnt0_d    = arb_gnt0;
        gnt1_d    = arb_gnt1;
        wr_en_d   = arb_gnt0 | arb_gnt1;
        ptr_d     = arb_ptr;
        wr_addr_d = arb_addr;
        wr_data_d = arb_data;
        if (state_q == CLEAR) begin
            gnt0_d    = 1'b0;
            gnt1_d    = 1'b0;
            wr_en_d   = 1'b1;
            ptr_d     = ptr_q;
            wr_addr_d = ADDR_W'(cnt_q);
            wr_data_d = '0;
            busy_d    = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
                cnt_d   = '0;
                state_d = ARB;
            end
        end
    end

    assign bus.busy = busy_q;
`else
    always_comb begin
        gnt0_d    = arb_gnt0;
        gnt1_d    = arb_gnt1;
        wr_en_d   = arb_gnt0 | arb_gnt1;
        ptr_d     = arb_ptr;
        wr_addr_d = arb_addr;
        wr_data_d = arb_data;
    end

    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            ptr_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            wr_en_q   <= wr_en_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule
